// File: rtl/mem_access_controller.sv
// mem_access_controller
//   Sequencer between the control unit and the external memory bus. Takes one
//   read or write request at a time, runs the bus handshake (with wait
//   states), positions store data on the byte lanes, aligns and extends load
//   data, and loads the Memory Data Register via a one-cycle mdr_write pulse.
//
//   Optional feature: define MEM_TIMEOUT_EN to abort an access after
//   TIMEOUT_CYCLES ACCESS cycles without bus_ready (reported on timeout_err).
//   Without it, ACCESS waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   mem_read/write   request strobes from the control unit (sampled in IDLE)
//   addr, wdata      byte address and right-justified store data
//   size, sign_ext   00 byte / 01 half / 1x word; sign- or zero-extend loads
//   busy, done       busy in ACCESS/RESP; done pulses once per request
//   mdr_write/data   MDR load pulse and aligned load data
//   misaligned       alignment fault, pulses with done
//   timeout_err      bus timeout, pulses with done
//   bus_*            word-aligned memory bus with byte enables and handshake

// One byte lane: byte-enable bit and store byte for lane LANE.
module mac_lane #(
    parameter int LANE  = 0,
    parameter int VEC_W = 8
) (
    input  logic [1:0]       size,
    input  logic [1:0]       k,
    input  logic [VEC_W-1:0] byte_b,  // candidate for a byte store
    input  logic [VEC_W-1:0] byte_h,  // candidate for a half store
    input  logic [VEC_W-1:0] byte_w,  // candidate for a word store
    output logic             be,
    output logic [VEC_W-1:0] wbyte
);
    always_comb begin
        be    = 1'b0;
        wbyte = byte_w;
        case (size)
            2'b00: begin
                be    = ({1'b0, k} == 3'(LANE));
                wbyte = byte_b;
            end
            2'b01: begin
                // Matches 4'b0011 << k truncated to four lanes.
                be    = ({1'b0, k} == 3'(LANE)) || (({1'b0, k} + 3'd1) == 3'(LANE));
                wbyte = byte_h;
            end
            default: be = 1'b1;
        endcase
    end
endmodule

module mem_access_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic                  busy,
    output logic                  done,
    output logic                  mdr_write,
    output logic [DATA_WIDTH-1:0] mdr_data,
    output logic                  misaligned,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ready
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic       is_write;
        logic       fault;     // misaligned; never reaches the bus
        logic [1:0] k;         // byte offset within the word
        logic [1:0] size;
        logic       sign_ext;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q;

    logic                                accept;
    logic                                misalign_in;
    logic                                ready_hit;
    logic                                expire;
    logic                                to_flag;
    logic [NUM_LANES-1:0]                lane_be;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_wdata;
    logic [ADDR_WIDTH-1:0]               bus_addr_q;
    logic [3:0]                          bus_be_q;
    logic [DATA_WIDTH-1:0]               bus_wdata_q;
    logic [DATA_WIDTH-1:0]               mdr_data_q;
    logic [DATA_WIDTH-1:0]               rd_aligned;
    logic [7:0]                          rd_byte;
    logic [15:0]                         rd_half;

    assign accept      = (state == S_IDLE) && (mem_read || mem_write);
    assign misalign_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign ready_hit   = (state == S_ACCESS) && bus_ready;

    // Store lanes, computed from the live request and captured at accept.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
            .size   (size),
            .k      (addr[1:0]),
            .byte_b (wdata[7:0]),
            .byte_h (wdata[VEC_W*(i%2) +: VEC_W]),
            .byte_w (wdata[VEC_W*i +: VEC_W]),
            .be     (lane_be[i]),
            .wbyte  (lane_wdata[i])
        );
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // Expiry on the TIMEOUT_CYCLES-th idle ACCESS cycle; bus_ready in that
    // same cycle takes priority and completes the access normally.
    assign expire = (state == S_ACCESS) && !bus_ready &&
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (accept)
                to_cnt <= '0;
            else if ((state == S_ACCESS) && !bus_ready)
                to_cnt <= to_cnt + CNT_W'(1);
            if (accept)
                to_flag <= 1'b0;
            else if (expire)
                to_flag <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign to_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = misalign_in ? S_RESP : S_ACCESS;
            S_ACCESS: if (bus_ready || expire) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Load alignment and extension from the captured offset/size.
    always_comb begin
        rd_byte = bus_rdata[{req_q.k, 3'b000} +: 8];
        rd_half = bus_rdata[{req_q.k[1], 4'b0000} +: 16];
        case (req_q.size)
            2'b00:   rd_aligned = {{24{req_q.sign_ext & rd_byte[7]}}, rd_byte};
            2'b01:   rd_aligned = {{16{req_q.sign_ext & rd_half[15]}}, rd_half};
            default: rd_aligned = bus_rdata;
        endcase
    end

    // Request capture and MDR data. Bus-facing registers hold their value
    // outside ACCESS; only the strobes qualify them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            mdr_data_q  <= '0;
        end else begin
            if (accept) begin
                req_q       <= '{is_write: mem_write, fault: misalign_in, k: addr[1:0],
                                 size: size, sign_ext: sign_ext};
                bus_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                bus_be_q    <= lane_be;
                bus_wdata_q <= lane_wdata;
            end
            if (ready_hit && !req_q.is_write)
                mdr_data_q <= rd_aligned;
        end
    end

    // Outputs
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_RESP);
    assign misaligned  = (state == S_RESP) && req_q.fault;
    assign timeout_err = (state == S_RESP) && to_flag;
    assign mdr_write   = (state == S_RESP) && !req_q.is_write && !req_q.fault && !to_flag;
    assign mdr_data    = mdr_data_q;
    assign bus_rd      = (state == S_ACCESS) && !req_q.is_write;
    assign bus_wr      = (state == S_ACCESS) && req_q.is_write;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
module tb_mem_access_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, sign_ext, bus_ready;
    logic [31:0] addr, wdata, bus_rdata;
    logic [1:0]  size;
    logic        busy, done, mdr_write, misaligned, timeout_err, bus_rd, bus_wr;
    logic [31:0] mdr_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_mdr = '0;

    mem_access_controller dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
        .busy(busy), .done(done), .mdr_write(mdr_write), .mdr_data(mdr_data),
        .misaligned(misaligned), .timeout_err(timeout_err), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] mdr;
        logic        mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on byte counts and masks.
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] s, input logic [1:0] k);
        logic [7:0] t;
        t = 8'(((1 << nbytes(s)) - 1) << k);
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] s, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = nbytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] s, input logic [1:0] k,
                                         input logic sx, input logic [31:0] rd);
        longint unsigned v, mask;
        int n;
        n = nbytes(s);
        if (n == 4) return rd;
        v    = 64'(rd) >> (8 * k);
        mask = (64'd1 << (8 * n)) - 1;
        v    = v & mask;
        if (sx && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic m_mis(input logic [1:0] s, input logic [31:0] a);
        int n;
        n = nbytes(s);
        return ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
    endfunction

    // One complete request, checked cycle by cycle.
    task automatic run_txn(input vec_t v);
        @(posedge clk); #1;
        mem_write = v.wr; mem_read = !v.wr; addr = v.addr; size = v.size;
        sign_ext = v.sx; wdata = v.wdata; bus_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        addr = $urandom; wdata = $urandom; size = 2'($urandom); sign_ext = 1'($urandom);
        if (v.mis) begin
            @(negedge clk);
            chk("mis_done", done, 1);
            chk("mis_flag", misaligned, 1);
            chk("mis_mdr_write", mdr_write, 0);
            chk("mis_strobe", {bus_rd, bus_wr}, 0);
            chk("mis_mdr_data", mdr_data, exp_mdr);
        end else begin
            for (int c = 0; c <= v.waits; c++) begin
                bus_ready = (c == v.waits);
                bus_rdata = (c == v.waits) ? v.rdata : $urandom;
                @(negedge clk);
                chk("strobe", {bus_rd, bus_wr}, v.wr ? 2'b01 : 2'b10);
                chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
                chk("bus_be", bus_be, v.be);
                if (v.wr) chk("bus_wdata", bus_wdata, v.bwd);
                chk("early_done", done, 0);
                @(posedge clk); #1;
            end
            bus_ready = 1'b0;
            @(negedge clk);
            chk("done", done, 1);
            chk("mdr_write", mdr_write, !v.wr);
            if (!v.wr) exp_mdr = v.mdr;
            chk("mdr_data", mdr_data, exp_mdr);
            chk("resp_strobe", {bus_rd, bus_wr}, 0);
            chk("resp_flags", {misaligned, timeout_err}, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after", {busy, done, mdr_write}, 0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        32'hA5A5A5A5, 0,  4'b1111, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[1] = '{1'b0, 32'h103, 2'b00, 1'b1, 32'h0,        32'h80123456, 0,  4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2] = '{1'b0, 32'h103, 2'b00, 1'b0, 32'h0,        32'h80123456, 1,  4'b1000, 32'h0,        32'h00000080, 1'b0};
        tbl[3] = '{1'b1, 32'h202, 2'b01, 1'b0, 32'h0000BEEF, 32'h0,        3,  4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0};
        tbl[4] = '{1'b0, 32'h101, 2'b10, 1'b0, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[5] = '{1'b0, 32'h102, 2'b01, 1'b1, 32'h0,        32'h80017FFF, 15, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[6] = '{1'b1, 32'h001, 2'b00, 1'b0, 32'h123456AB, 32'h0,        2,  4'b0010, 32'hABABABAB, 32'h0,        1'b0};
        tbl[7] = '{1'b0, 32'h001, 2'b01, 1'b0, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[8] = '{1'b0, 32'h002, 2'b00, 1'b1, 32'h0,        32'h007F0000, 0,  4'b0100, 32'h0,        32'h0000007F, 1'b0};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        size = '0; sign_ext = 1'b0; bus_rdata = '0; bus_ready = 1'b0;
        #3;
        chk("rst_ctrl", {busy, done, mdr_write, misaligned, timeout_err, bus_rd, bus_wr}, 0);
        chk("rst_mdr", mdr_data, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Request pulsed while busy is dropped, not queued
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h400; size = 2'b10;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; bus_ready = 1'b0;
        @(posedge clk); #1;
        mem_write = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h13579BDF;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(negedge clk);
        chk("busy_req_done", done, 1);
        exp_mdr = 32'h13579BDF;
        chk("busy_req_mdr", mdr_data, exp_mdr);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_req_ignored", {busy, bus_wr}, 0);
        end

        // Back-to-back: write held high through RESP is re-accepted from IDLE
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h500; size = 2'b10; wdata = 32'hCAFEF00D; bus_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            logic [2:0] e;
            @(posedge clk); #1;
            if (c == 4) mem_write = 1'b0;
            @(negedge clk);
            e = (c == 1 || c == 4) ? 3'b101 : ((c == 2 || c == 5) ? 3'b011 : 3'b000);
            chk("b2b_wr_done_busy", {bus_wr, done, busy}, e);
        end
        bus_ready = 1'b0;

        // Reset in the middle of a read access
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h300; size = 2'b10;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd_before", bus_rd, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_rd", {bus_rd, busy, done, mdr_write}, 0);
        exp_mdr = '0;
        chk("rst_mid_mdr", mdr_data, exp_mdr);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_after", {busy, done, mdr_write}, 0);
        run_txn(tbl[0]);

        // Stalled bus
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h600; size = 2'b10; bus_ready = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("to_wait_rd", {bus_rd, done, timeout_err}, 3'b100);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_resp", {done, timeout_err, mdr_write, bus_rd}, 4'b1100);
        chk("to_mdr", mdr_data, exp_mdr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_idle", {busy, done, timeout_err}, 0);
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_rd", {bus_rd, done, timeout_err}, 3'b100);
            @(posedge clk); #1;
        end
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(negedge clk);
        exp_mdr = 32'h0BADF00D;
        chk("stall_resp", {done, mdr_write, timeout_err}, 3'b110);
        chk("stall_mdr", mdr_data, exp_mdr);
        @(posedge clk); #1;
`endif

        // Randomized requests against the reference model
        for (int i = 0; i < 60; i++) begin
            rv.wr    = 1'($urandom);
            rv.addr  = $urandom & 32'h0000FFFF;
            rv.size  = 2'($urandom);
            rv.sx    = 1'($urandom);
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.waits = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
            rv.be    = m_be(rv.size, rv.addr[1:0]);
            rv.bwd   = m_wd(rv.size, rv.wdata);
            rv.mdr   = m_rd(rv.size, rv.addr[1:0], rv.sx, rv.rdata);
            rv.mis   = m_mis(rv.size, rv.addr);
            run_txn(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
Sequencer between the control unit and the external memory bus.
- Accepts one read or write request at a time.
- Runs the bus handshake, including wait states.
- Aligns and extends read data, then loads it into the Memory Data Register through a one-cycle write pulse.
- Sits directly upstream of the MDR: drives the MDR write enable and data input.

Parameters:
ADDR_WIDTH, 32, byte address width (from MAR)
DATA_WIDTH, 32, data width; fixed at 32, four byte lanes
TIMEOUT_CYCLES, 16, ACCESS cycles without bus_ready before abort (MEM_TIMEOUT_EN only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
mem_read  in  1  read request, sampled in IDLE
mem_write  in  1  write request, sampled in IDLE
addr  in  ADDR_WIDTH  byte address
wdata  in  32  store data, right-justified
size  in  2  00 byte, 01 half, 10/11 word
sign_ext  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
busy  out  1  high in ACCESS and RESP
done  out  1  one-cycle completion pulse, reads and writes
mdr_write  out  1  one-cycle load pulse to MDR; successful reads only
mdr_data  out  32  aligned, extended read data to MDR data_in
misaligned  out  1  one-cycle pulse with done on an alignment fault
timeout_err  out  1  one-cycle pulse with done on a bus timeout
bus_addr  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2],2'b00}
bus_rd  out  1  read strobe, held until bus_ready
bus_wr  out  1  write strobe, held until bus_ready
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  lane-positioned store data
bus_rdata  in  32  memory read data, valid with bus_ready
bus_ready  in  1  memory completion, sampled in ACCESS

Behaviour:
Reset (async):
- State = IDLE.
- All outputs = 0, including mdr_data, bus_addr, bus_be and bus_wdata.
- Reset during ACCESS drops the strobes immediately; no done or mdr_write is issued.

FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If mem_write, accept a write (write wins if mem_read is also high).
  - Else if mem_read, accept a read.
  - Otherwise stay in IDLE.
  - On accept, register addr, size, sign_ext and wdata, then go to ACCESS with bus_rd/bus_wr, bus_addr, bus_be and bus_wdata valid from the next cycle.
- Alignment check at accept: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request skips ACCESS and goes to RESP.
  - RESP then shows misaligned=1, done=1, mdr_write=0.
  - No bus strobe is ever asserted.
- ACCESS:
  - Strobe and bus outputs are held stable.
  - On bus_ready=1, bus_rdata is captured, strobes drop on the next edge, and state goes to RESP.
- RESP: lasts one cycle. done=1; for reads also mdr_write=1 and mdr_data valid. Then return to IDLE.
- Requests while busy=1 are ignored, not queued.
- Latency with zero wait states: request seen at edge N, strobe in cycle N+1, done/mdr_write in N+2. Each cycle bus_ready stays low adds one cycle.
- Back-to-back: a request held high in the RESP cycle is accepted at the next IDLE edge.

Lane rules (k = addr[1:0]):
- bus_be: byte = 4'b0001<<k; half = 4'b0011<<k; word = 4'b1111.
- bus_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Read: extract byte bus_rdata[8k+7:8k] or half bus_rdata[8k+15:8k], then extend per sign_ext. Word is passed through unchanged.
- mdr_data holds its last value on writes and faults. It updates only on a successful read.

Optional Feature:
MEM_TIMEOUT_EN defined:
- A counter clears on entry to ACCESS and increments every ACCESS cycle with bus_ready=0.
- When it reaches TIMEOUT_CYCLES, strobes drop and state goes to RESP.
- RESP then shows timeout_err=1, done=1, mdr_write=0; mdr_data is unchanged.
- bus_ready arriving in the same cycle as expiry wins, and the access completes normally.

MEM_TIMEOUT_EN undefined:
- No counter; ACCESS waits indefinitely.
- timeout_err is tied to 0.

Test Plan:
- Word read, addr=0x100, bus_rdata=0xA5A5A5A5, bus_ready on first ACCESS cycle -> bus_rd for 1 cycle, bus_be=1111, done+mdr_write 2 cycles after request, mdr_data=0xA5A5A5A5.
- Byte read, addr=0x103, sign_ext=1, bus_rdata=0x80123456 -> bus_be=1000, mdr_data=0xFFFFFF80. Repeat with sign_ext=0 -> 0x00000080.
- Half write, addr=0x202, wdata=0x0000BEEF, bus_ready after 3 wait cycles -> bus_wr held 4 cycles, bus_addr=0x200, bus_be=1100, bus_wdata=0xBEEFBEEF, done=1, mdr_write=0, mdr_data unchanged.
- Word read, addr=0x101 -> no bus strobe, misaligned=1 and done=1 one cycle after request, mdr_write=0.
- Reset asserted mid-ACCESS on a read -> bus_rd=0 immediately, no done, mdr_data=0. A fresh read after reset completes normally.
- With MEM_TIMEOUT_EN and bus_ready held 0 -> after 16 ACCESS cycles, timeout_err=1 and done=1, mdr_write=0, busy then falls.
